// File: rtl/risc_core_seq_if.sv
// Memory bus between the accumulator core and an external wait-state memory.
//   mem_addr  : word address driven by the core
//   mem_rd    : read strobe
//   mem_wr    : write strobe (never together with mem_rd)
//   mem_wdata : store data, zero while mem_wr is low
//   mem_rdata : read data, sampled on the completing edge
//   mem_ready : completes the pending access on a rising edge
// master = core side, slave = memory side.
interface risc_core_seq_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 5
);
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic              mem_wr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   modport master (
      output mem_addr, mem_rd, mem_wr, mem_wdata,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_addr, mem_rd, mem_wr, mem_wdata,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/risc_core_seq.sv
// Multi-cycle accumulator CPU: PC, IR, accumulator, ALU and a
// START/FETCH/DECODE/READ/WRITE/HALT controller talking to an external
// memory with a ready handshake.
//   clock   : rising-edge clock
//   reset   : asynchronous active-low reset
//   mem     : memory bus (master side of risc_core_seq_if)
//   resume  : leaves HALT when sampled high in HALT
//   halted  : high while in HALT
//   pc_out  : program counter
//   acc_out : accumulator
//   zero    : combinational acc==0
// Instruction: opcode = ir[DATA_W-1 -: 3], operand address = ir[ADDR_W-1:0].
module risc_core_seq #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 5
) (
   input  logic                 clock,
   input  logic                 reset,
   risc_core_seq_if.master      mem,
   input  logic                 resume,
   output logic                 halted,
   output logic [ADDR_W-1:0]    pc_out,
   output logic [DATA_W-1:0]    acc_out,
   output logic                 zero
);

   localparam int unsigned OP_W = 3;

   localparam logic [OP_W-1:0] OP_HLT = 3'b000;
   localparam logic [OP_W-1:0] OP_SKZ = 3'b001;
   localparam logic [OP_W-1:0] OP_ADD = 3'b010;
   localparam logic [OP_W-1:0] OP_AND = 3'b011;
   localparam logic [OP_W-1:0] OP_XOR = 3'b100;
   localparam logic [OP_W-1:0] OP_LDA = 3'b101;
   localparam logic [OP_W-1:0] OP_STO = 3'b110;
   localparam logic [OP_W-1:0] OP_JMP = 3'b111;

   typedef enum logic [2:0] {
      S_START  = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_READ   = 3'd3,
      S_WRITE  = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic [DATA_W-1:0] acc_q, acc_d;

   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_rd_q, mem_rd_d;
   logic              mem_wr_q, mem_wr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              halted_q, halted_d;

   logic [OP_W-1:0]   opcode;
   logic [ADDR_W-1:0] ir_addr_q;
   logic [ADDR_W-1:0] ir_addr_d;

   assign opcode    = ir_q[DATA_W-1 -: OP_W];
   assign ir_addr_q = ir_q[ADDR_W-1:0];
   assign ir_addr_d = ir_d[ADDR_W-1:0];

   // Middle instruction bits carry no meaning.
   if (DATA_W > ADDR_W + OP_W) begin : g_unused_ir
      logic unused_ir_bits;
      assign unused_ir_bits = ^ir_q[DATA_W-OP_W-1:ADDR_W];
   end

   // State, datapath and registered bus outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= S_START;
         pc_q        <= '0;
         ir_q        <= '0;
         acc_q       <= '0;
         mem_addr_q  <= '0;
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_wdata_q <= '0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         acc_q       <= acc_d;
         mem_addr_q  <= mem_addr_d;
         mem_rd_q    <= mem_rd_d;
         mem_wr_q    <= mem_wr_d;
         mem_wdata_q <= mem_wdata_d;
         halted_q    <= halted_d;
      end
   end

   // Next state and datapath updates.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      acc_d   = acc_q;
      case (state_q)
         S_START: state_d = S_FETCH;
         S_FETCH: begin
            if (mem.mem_ready) begin
               ir_d    = mem.mem_rdata;
               pc_d    = pc_q + ADDR_W'(1);
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            case (opcode)
               OP_HLT: state_d = S_HALT;
               OP_SKZ: begin
                  if (acc_q == '0) pc_d = pc_q + ADDR_W'(1);
                  state_d = S_FETCH;
               end
               OP_JMP: begin
                  pc_d    = ir_addr_q;
                  state_d = S_FETCH;
               end
               OP_STO:  state_d = S_WRITE;
               default: state_d = S_READ;
            endcase
         end
         S_READ: begin
            if (mem.mem_ready) begin
               case (opcode)
                  OP_ADD:  acc_d = acc_q + mem.mem_rdata;
                  OP_AND:  acc_d = acc_q & mem.mem_rdata;
                  OP_XOR:  acc_d = acc_q ^ mem.mem_rdata;
                  OP_LDA:  acc_d = mem.mem_rdata;
                  default: acc_d = acc_q;
               endcase
               state_d = S_FETCH;
            end
         end
         S_WRITE: begin
            if (mem.mem_ready) state_d = S_FETCH;
         end
         S_HALT: begin
            if (resume) state_d = S_FETCH;
         end
         default: state_d = S_START;
      endcase
   end

   // Bus outputs for the coming state, so they launch straight from flops.
   always_comb begin
      mem_addr_d  = '0;
      mem_rd_d    = 1'b0;
      mem_wr_d    = 1'b0;
      mem_wdata_d = '0;
      halted_d    = 1'b0;
      case (state_d)
         S_FETCH: begin
            mem_addr_d = pc_d;
            mem_rd_d   = 1'b1;
         end
         S_READ: begin
            mem_addr_d = ir_addr_d;
            mem_rd_d   = 1'b1;
         end
         S_WRITE: begin
            mem_addr_d  = ir_addr_d;
            mem_wr_d    = 1'b1;
            mem_wdata_d = acc_d;
         end
         S_HALT:  halted_d = 1'b1;
         default: ;
      endcase
   end

   assign mem.mem_addr  = mem_addr_q;
   assign mem.mem_rd    = mem_rd_q;
   assign mem.mem_wr    = mem_wr_q;
   assign mem.mem_wdata = mem_wdata_q;

   assign halted  = halted_q;
   assign pc_out  = pc_q;
   assign acc_out = acc_q;
   assign zero    = (acc_q == '0);

endmodule

// File: tb/tb_risc_core_seq.sv
// Bench for risc_core_seq: directed programs plus random programs checked
// against an instruction-level reference model of the accumulator ISA.
module tb_risc_core_seq;

   localparam int unsigned DW = 8;
   localparam int unsigned AW = 5;
   localparam int unsigned MS = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          resume;
   logic          halted;
   logic [AW-1:0] pc_out;
   logic [DW-1:0] acc_out;
   logic          zero;

   always #5 clk = ~clk;

   risc_core_seq_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   risc_core_seq #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clock   (clk),
      .reset   (rst_n),
      .mem     (bus),
      .resume  (resume),
      .halted  (halted),
      .pc_out  (pc_out),
      .acc_out (acc_out),
      .zero    (zero)
   );

   // Memory model: image loaded while in reset, bus accesses logged.
   logic [DW-1:0] img [MS];
   logic [DW-1:0] mem [MS];
   int            dut_trace [$];
   int            hs_cnt = 0;

   assign bus.mem_rdata = mem[bus.mem_addr];

   always @(posedge clk) begin
      if (!rst_n) begin
         mem = img;
         dut_trace.delete();
      end else begin
         if (bus.mem_ready && bus.mem_rd) begin
            dut_trace.push_back(32'h1_0000 | 32'(bus.mem_addr));
            hs_cnt++;
         end
         if (bus.mem_ready && bus.mem_wr) begin
            mem[bus.mem_addr] = bus.mem_wdata;
            dut_trace.push_back(32'h2_0000 | (32'(bus.mem_wdata) << 8) | 32'(bus.mem_addr));
            hs_cnt++;
         end
      end
   end

   int vectors = 0;
   int errs    = 0;

   task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: executes whole instructions on its own memory copy.
   logic [DW-1:0] m_mem [MS];
   int            exp_trace [$];
   int unsigned   m_acc, m_pc, m_cycles;

   function automatic bit model_run(int max_instr);
      int unsigned ir, op, a;
      exp_trace.delete();
      m_acc = 0; m_pc = 0; m_cycles = 0;
      for (int n = 0; n < max_instr; n++) begin
         ir = 32'(m_mem[m_pc]);
         op = ir >> 5;
         a  = ir % 32;
         exp_trace.push_back(32'h1_0000 | m_pc);
         m_pc = (m_pc + 1) % 32;
         case (op)
            0: begin m_cycles += 2; return 1'b1; end
            1: begin m_cycles += 2; if (m_acc == 0) m_pc = (m_pc + 1) % 32; end
            7: begin m_cycles += 2; m_pc = a; end
            6: begin
               m_cycles += 3;
               m_mem[a] = 8'(m_acc);
               exp_trace.push_back(32'h2_0000 | (m_acc << 8) | a);
            end
            default: begin
               m_cycles += 3;
               exp_trace.push_back(32'h1_0000 | a);
               case (op)
                  2: m_acc = (m_acc + 32'(m_mem[a])) % 256;
                  3: m_acc = m_acc & 32'(m_mem[a]);
                  4: m_acc = m_acc ^ 32'(m_mem[a]);
                  default: m_acc = 32'(m_mem[a]);
               endcase
            end
         endcase
      end
      return 1'b0;
   endfunction

   // Ready policy and per-cycle bus monitor, evaluated on falling edges.
   bit            rand_wait = 0;
   int            fixed_wait = 0;
   bit            stall_wr = 0;
   int            last_hs = 0;
   int            wcnt = 0;
   int            cur_wait = 0;
   bit            prev_stall = 0;
   logic [AW-1:0] p_addr;
   logic          p_rd, p_wr;
   logic [DW-1:0] p_wd, p_acc;

   task automatic tick();
      @(negedge clk);
      if (!rst_n) prev_stall = 0;
      else begin
         if (prev_stall) begin
            check_eq("stall_addr", 32'(bus.mem_addr), 32'(p_addr));
            check_eq("stall_rd", 32'(bus.mem_rd), 32'(p_rd));
            check_eq("stall_wr", 32'(bus.mem_wr), 32'(p_wr));
            check_eq("stall_wdata", 32'(bus.mem_wdata), 32'(p_wd));
            check_eq("stall_acc", 32'(acc_out), 32'(p_acc));
         end
         check_eq("rd_wr_excl", 32'(bus.mem_rd & bus.mem_wr), 0);
         if (!bus.mem_wr) check_eq("wdata_idle", 32'(bus.mem_wdata), 0);
      end
      if (hs_cnt != last_hs) begin
         last_hs  = hs_cnt;
         wcnt     = 0;
         cur_wait = rand_wait ? int'($urandom_range(0, 2)) : fixed_wait;
      end
      if (bus.mem_wr && stall_wr) bus.mem_ready = 1'b0;
      else if (bus.mem_rd || bus.mem_wr) begin
         if (wcnt >= cur_wait) bus.mem_ready = 1'b1;
         else begin
            bus.mem_ready = 1'b0;
            wcnt++;
         end
      end else bus.mem_ready = 1'($urandom_range(0, 1));
      prev_stall = rst_n && (bus.mem_rd || bus.mem_wr) && !bus.mem_ready;
      p_addr = bus.mem_addr; p_rd = bus.mem_rd; p_wr = bus.mem_wr;
      p_wd = bus.mem_wdata; p_acc = acc_out;
   endtask

   task automatic apply_reset();
      rst_n  = 1'b0;
      resume = 1'b0;
      tick();
      tick();
      check_eq("rst_pc", 32'(pc_out), 0);
      check_eq("rst_acc", 32'(acc_out), 0);
      check_eq("rst_rd", 32'(bus.mem_rd), 0);
      check_eq("rst_wr", 32'(bus.mem_wr), 0);
      check_eq("rst_addr", 32'(bus.mem_addr), 0);
      check_eq("rst_halted", 32'(halted), 0);
      check_eq("rst_zero", 32'(zero), 1);
      wcnt     = 0;
      cur_wait = rand_wait ? int'($urandom_range(0, 2)) : fixed_wait;
      last_hs  = hs_cnt;
      rst_n    = 1'b1;
   endtask

   task automatic run_to_halt(int limit, output int cyc, output bit done);
      int first = -1;
      int n = 0;
      done = 1'b0;
      while (n < limit) begin
         tick();
         n++;
         if (first < 0 && bus.mem_rd) first = n;
         if (halted) begin
            done = 1'b1;
            break;
         end
      end
      cyc = (first < 0) ? -1 : n - first;
   endtask

   task automatic prepare(output bit ok);
      m_mem = img;
      ok = model_run(64);
   endtask

   task automatic clear_img();
      for (int i = 0; i < int'(MS); i++) img[i] = '0;
   endtask

   task automatic compare_final(string t);
      int n;
      check_eq({t, "_acc"}, 32'(acc_out), m_acc);
      check_eq({t, "_pc"}, 32'(pc_out), m_pc);
      check_eq({t, "_halted"}, 32'(halted), 1);
      check_eq({t, "_zero"}, 32'(zero), (m_acc == 0) ? 1 : 0);
      for (int i = 0; i < int'(MS); i++)
         check_eq($sformatf("%s_mem%0d", t, i), 32'(mem[i]), 32'(m_mem[i]));
      check_eq({t, "_trace_len"}, dut_trace.size(), exp_trace.size());
      n = (dut_trace.size() < exp_trace.size()) ? dut_trace.size() : exp_trace.size();
      for (int i = 0; i < n; i++)
         check_eq($sformatf("%s_acc%0d", t, i), dut_trace[i], exp_trace[i]);
   endtask

   initial begin
      int cyc;
      bit done, ok;
      rst_n  = 1'b0;
      resume = 1'b0;

      // LDA/ADD/STO/HLT with zero wait states, then halt hold and resume.
      clear_img();
      img[0] = 8'hAA; img[1] = 8'h4B; img[2] = 8'hCC; img[3] = 8'h00;
      img[10] = 8'h05; img[11] = 8'hFC;
      prepare(ok);
      apply_reset();
      run_to_halt(200, cyc, done);
      check_eq("t1_done", 32'(done), 1);
      check_eq("t1_cycles", cyc, 11);
      check_eq("t1_mem12", 32'(mem[12]), 32'h01);
      check_eq("t1_acc", 32'(acc_out), 32'h01);
      check_eq("t1_pc", 32'(pc_out), 4);
      compare_final("t1");
      repeat (5) begin
         tick();
         check_eq("hold_halted", 32'(halted), 1);
         check_eq("hold_rd", 32'(bus.mem_rd), 0);
         check_eq("hold_wr", 32'(bus.mem_wr), 0);
      end
      resume = 1'b1;
      tick();
      resume = 1'b0;
      check_eq("resume_halted", 32'(halted), 0);
      check_eq("resume_rd", 32'(bus.mem_rd), 1);
      check_eq("resume_addr", 32'(bus.mem_addr), 4);

      // Same program with three wait states on every access.
      fixed_wait = 3;
      prepare(ok);
      apply_reset();
      run_to_halt(400, cyc, done);
      check_eq("t3_done", 32'(done), 1);
      check_eq("t3_acc", 32'(acc_out), 32'h01);
      check_eq("t3_mem12", 32'(mem[12]), 32'h01);
      compare_final("t3");
      fixed_wait = 0;

      // XOR to zero, SKZ over HLT, JMP 7.
      clear_img();
      img[0] = 8'hAA; img[1] = 8'h8A; img[2] = 8'h20; img[3] = 8'h00;
      img[4] = 8'hE7; img[7] = 8'h00; img[10] = 8'h5A;
      prepare(ok);
      apply_reset();
      run_to_halt(200, cyc, done);
      check_eq("t2_done", 32'(done), 1);
      check_eq("t2_zero", 32'(zero), 1);
      check_eq("t2_pc", 32'(pc_out), 8);
      compare_final("t2");

      // PC wrap at 31 with acc nonzero: fetch returns to 0.
      clear_img();
      img[0] = 8'hB4; img[1] = 8'hFF; img[31] = 8'h20; img[20] = 8'h05;
      prepare(ok);
      apply_reset();
      repeat (12) tick();
      check_eq("t4a_len", (dut_trace.size() >= 5) ? 1 : 0, 1);
      check_eq("t4a_fetch", (dut_trace.size() >= 5) ? dut_trace[4] : -1, 32'h1_0000);

      // PC wrap with acc zero: skip lands on address 1.
      clear_img();
      img[0] = 8'hFF; img[31] = 8'h20; img[1] = 8'h00;
      prepare(ok);
      apply_reset();
      run_to_halt(200, cyc, done);
      check_eq("t4b_done", 32'(done), 1);
      check_eq("t4b_fetch", (dut_trace.size() >= 3) ? dut_trace[2] : -1, 32'h1_0001);
      check_eq("t4b_pc", 32'(pc_out), 2);
      compare_final("t4b");

      // Reset in the middle of a stalled write.
      clear_img();
      img[0] = 8'hAA; img[1] = 8'hCC; img[10] = 8'h33;
      stall_wr = 1;
      prepare(ok);
      apply_reset();
      for (int i = 0; i < 30 && !bus.mem_wr; i++) tick();
      check_eq("t5_wr_seen", 32'(bus.mem_wr), 1);
      check_eq("t5_acc_pre", 32'(acc_out), 32'h33);
      check_eq("t5_pc_pre", 32'(pc_out), 2);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("t5_wr", 32'(bus.mem_wr), 0);
      check_eq("t5_rd", 32'(bus.mem_rd), 0);
      check_eq("t5_pc", 32'(pc_out), 0);
      check_eq("t5_acc", 32'(acc_out), 0);
      check_eq("t5_wdata", 32'(bus.mem_wdata), 0);
      stall_wr = 0;
      tick();
      tick();
      rst_n = 1'b1;
      check_eq("t5_start_rd", 32'(bus.mem_rd), 0);
      tick();
      check_eq("t5_fetch_rd", 32'(bus.mem_rd), 1);
      check_eq("t5_fetch_addr", 32'(bus.mem_addr), 0);

      // Random programs that the model shows will halt.
      for (int k = 0; k < 40; k++) begin
         rand_wait = (k % 2 == 1);
         ok = 1'b0;
         for (int t = 0; t < 20 && !ok; t++) begin
            for (int i = 0; i < int'(MS); i++) img[i] = 8'($urandom);
            prepare(ok);
         end
         if (!ok) begin
            img[0] = 8'h00;
            prepare(ok);
         end
         apply_reset();
         run_to_halt(2000, cyc, done);
         check_eq($sformatf("r%0d_done", k), 32'(done), 1);
         if (!rand_wait) check_eq($sformatf("r%0d_cycles", k), cyc, m_cycles);
         compare_final($sformatf("r%0d", k));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule

// File: doc/risc_core_seq.md
Name: risc_core_seq

Overview:
Parametrised successor to the 8-bit accumulator CPU top. It integrates the program counter, instruction register, accumulator, ALU and a multi-cycle fetch/decode/execute controller into one block. Memory is external on separate read/write data buses with a ready handshake, so the core supports wait-state memories. A halt/resume mechanism is included.

Parameters:
DATA_W, 8, accumulator/memory word width; instruction word is also DATA_W bits; must satisfy DATA_W >= ADDR_W+3
ADDR_W, 5, address width; PC range 0..2^ADDR_W-1

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
mem_addr  out  ADDR_W  memory address
mem_rd  out  1  read strobe
mem_wr  out  1  write strobe
mem_wdata  out  DATA_W  write data (= acc while mem_wr)
mem_rdata  in  DATA_W  read data, valid when mem_ready=1 during a read
mem_ready  in  1  access completes on a rising edge where strobe=1 and mem_ready=1
resume  in  1  leaves HALT when high in HALT state
halted  out  1  high in HALT state
pc_out  out  ADDR_W  current PC
acc_out  out  DATA_W  accumulator
zero  out  1  combinational (acc==0)

Behaviour:
- Instruction format: opcode = ir[DATA_W-1:DATA_W-3]; operand address = ir[ADDR_W-1:0]; unused middle bits ignored.
- Opcodes: 000 HLT, 001 SKZ, 010 ADD, 011 AND, 100 XOR, 101 LDA, 110 STO, 111 JMP.
- Reset (reset=0, async): state=START, pc=0, acc=0, ir=0, mem_rd=mem_wr=0, mem_addr=0, mem_wdata=0, halted=0. Strobes drop in the same cycle reset asserts, including mid-access.
- States:
  - START: no strobes; -> FETCH next edge.
  - FETCH: mem_addr=pc, mem_rd=1. On mem_ready: ir<=mem_rdata, pc<=pc+1 (mod 2^ADDR_W), -> DECODE. Else stay; outputs held stable.
  - DECODE: no strobes.
    - HLT -> HALT.
    - SKZ: if acc==0 then pc<=pc+1 (wraps); -> FETCH.
    - JMP: pc<=ir addr; -> FETCH.
    - ADD/AND/XOR/LDA -> READ.
    - STO -> WRITE.
  - READ: mem_addr=ir addr, mem_rd=1. On mem_ready: acc<=acc+rdata (mod 2^DATA_W, carry discarded) / acc&rdata / acc^rdata / rdata; -> FETCH.
  - WRITE: mem_addr=ir addr, mem_wr=1, mem_wdata=acc. On mem_ready -> FETCH.
  - HALT: halted=1, no strobes, pc/acc frozen. resume=1 at edge -> FETCH (continues at pc, already past HLT).
- mem_rd and mem_wr are never high together. mem_ready is ignored outside FETCH/READ/WRITE. resume is ignored outside HALT.
- Strobes, mem_addr and mem_wdata decode from registered state/ir/pc/acc only; no combinational path from mem_ready or mem_rdata to any output.
- With zero wait states (mem_ready=1), cycles per instruction: HLT/SKZ/JMP 2, ALU/LDA/STO 3.
- While mem_wr=0, mem_wdata=0.

Test Plan:
- Program mem[0]=0xAA (LDA 10), [1]=0x4B (ADD 11), [2]=0xCC (STO 12), [3]=0x00 (HLT); mem[10]=0x05, [11]=0xFC; mem_ready=1 -> mem[12]=0x01, acc=0x01, halted=1, pc_out=4, total 11 cycles from first FETCH.
- mem[0]=0xAA, [1]=0x8A (XOR 10), [2]=0x20 (SKZ), [3]=0x00, [4]=0xE7 (JMP 7), [7]=0x00; mem[10]=0x5A -> zero=1 after XOR, HLT at 3 skipped, halt with pc_out=8.
- Same as test 1, mem_ready low 3 cycles in each READ -> mem_addr=10/11 and mem_rd held stable, acc unchanged until ready; final state identical.
- JMP 31 (0xFF), mem[31]=0x20 (SKZ) with acc=0x05 -> pc wraps 31->0, next fetch address 0. With acc=0: pc wraps to 0, skip -> next fetch address 1.
- reset low during WRITE with mem_ready=0 -> mem_wr falls immediately, pc=0, acc=0. After release: one START cycle, then FETCH at address 0.
- In HALT, hold resume=0 for 5 cycles -> no strobes, halted=1. Pulse resume -> next cycle FETCH at pc_out, halted=0.
